// File: rtl/spi_flash_reader.sv
// SPI flash read engine: command + 24-bit address, then N bytes out.
// Define FAST_READ_EN for command 0x0B with an 8-cycle dummy phase.
module spi_flash_reader #(
    parameter int SCLK_HALF = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [23:0] addr,
    input  logic [7:0]  len,
    output logic        busy,
    output logic        done,
    output logic [7:0]  data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        spi_sclk,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso
);

`ifdef FAST_READ_EN
    localparam logic [7:0] CMD = 8'h0B;
`else
    localparam logic [7:0] CMD = 8'h03;
`endif

    localparam logic [15:0] HALF    = 16'(SCLK_HALF);
    localparam logic [15:0] HALF_M1 = 16'(SCLK_HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_ADDR  = 3'd2,
`ifdef FAST_READ_EN
        S_DUMMY = 3'd3,
`endif
        S_DATA  = 3'd4,
        S_HOLD  = 3'd5,
        S_DRAIN = 3'd6
    } state_t;

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [31:0] tx_q;
    logic [4:0]  bit_q;
    logic [8:0]  left_q;
    logic [7:0]  rx_q;
    logic        pend_q;
    logic        stall_q;
    logic        busy_q;
    logic        done_q;
    logic        valid_q;
    logic [7:0]  dout_q;
    logic        sclk_q;
    logic        cs_n_q;
    logic        mosi_q;

    logic        shifting;
    logic        tick;
    logic        rise;
    logic        fall;
    logic        take;
    logic        pend_mv;
    logic [7:0]  rx_d;

    // SCLK phase decode, handshake and next received byte
    always_comb begin
        shifting = 1'b0;
        unique case (state_q)
            S_CMD, S_ADDR: shifting = 1'b1;
`ifdef FAST_READ_EN
            S_DUMMY:       shifting = 1'b1;
`endif
            S_DATA:        shifting = !stall_q;
            default:       shifting = 1'b0;
        endcase
        tick    = shifting && (cnt_q == 16'd0);
        rise    = tick && !sclk_q;
        fall    = tick && sclk_q;
        take    = valid_q && data_ready;
        pend_mv = pend_q && take;
        rx_d    = {rx_q[6:0], spi_miso};
    end

    // Transfer sequencer with registered pins and output buffer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            tx_q    <= 32'd0;
            bit_q   <= 5'd0;
            left_q  <= 9'd0;
            rx_q    <= 8'd0;
            pend_q  <= 1'b0;
            stall_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            dout_q  <= 8'd0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (take) begin
                valid_q <= 1'b0;
            end
            // a byte parked behind a full buffer moves up on handshake
            if (pend_mv) begin
                dout_q  <= rx_q;
                valid_q <= 1'b1;
                pend_q  <= 1'b0;
            end
            if (tick) begin
                sclk_q <= !sclk_q;
                cnt_q  <= HALF_M1;
            end else if (shifting) begin
                cnt_q <= cnt_q - 16'd1;
            end
            // zeros shift in behind the address, so MOSI idles low
            if (fall) begin
                tx_q   <= tx_q << 1;
                mosi_q <= tx_q[30];
            end
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q  <= 1'b1;
                        cs_n_q  <= 1'b0;
                        mosi_q  <= CMD[7];
                        tx_q    <= {CMD, addr};
                        cnt_q   <= HALF;
                        bit_q   <= 5'd0;
                        left_q  <= (len == 8'd0) ? 9'd256 : {1'b0, len};
                        state_q <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (fall) begin
                        if (bit_q == 5'd7) begin
                            bit_q   <= 5'd0;
                            state_q <= S_ADDR;
                        end else begin
                            bit_q <= bit_q + 5'd1;
                        end
                    end
                end
                S_ADDR: begin
                    if (fall) begin
                        if (bit_q == 5'd23) begin
                            bit_q   <= 5'd0;
`ifdef FAST_READ_EN
                            state_q <= S_DUMMY;
`else
                            state_q <= S_DATA;
`endif
                        end else begin
                            bit_q <= bit_q + 5'd1;
                        end
                    end
                end
`ifdef FAST_READ_EN
                S_DUMMY: begin
                    if (fall) begin
                        if (bit_q == 5'd7) begin
                            bit_q   <= 5'd0;
                            state_q <= S_DATA;
                        end else begin
                            bit_q <= bit_q + 5'd1;
                        end
                    end
                end
`endif
                S_DATA: begin
                    if (rise) begin
                        rx_q <= rx_d;
                        if (bit_q == 5'd7) begin
                            if (!valid_q || take) begin
                                dout_q  <= rx_d;
                                valid_q <= 1'b1;
                            end else begin
                                pend_q <= 1'b1;
                            end
                        end
                    end
                    if (fall) begin
                        if (bit_q == 5'd7) begin
                            bit_q  <= 5'd0;
                            left_q <= left_q - 9'd1;
                            if (left_q == 9'd1) begin
                                state_q <= S_HOLD;
                            end else if (pend_q && !pend_mv) begin
                                stall_q <= 1'b1;
                            end
                        end else begin
                            bit_q <= bit_q + 5'd1;
                        end
                    end
                    if (stall_q && pend_mv) begin
                        stall_q <= 1'b0;
                        cnt_q   <= HALF_M1;
                    end
                end
                S_HOLD: begin
                    if (cnt_q == 16'd0) begin
                        cs_n_q  <= 1'b1;
                        state_q <= S_DRAIN;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                S_DRAIN: begin
                    if (!valid_q && !pend_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign data_out   = dout_q;
    assign data_valid = valid_q;
    assign spi_sclk   = sclk_q;
    assign spi_cs_n   = cs_n_q;
    assign spi_mosi   = mosi_q;

endmodule
